// File: rtl/decode_reg.sv
// decode_reg: decode-to-execute pipeline register for the two operand paths, with stall hold
module decode_reg #(
    parameter int unsigned       WIDTH    = 16,
    parameter logic [WIDTH-1:0]  RST_VAL1 = 16'h0000,
    parameter logic [WIDTH-1:0]  RST_VAL2 = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Stall,
    input  logic [WIDTH-1:0] DataOut1In,
    input  logic [WIDTH-1:0] DataOut2In,
    output logic [WIDTH-1:0] DataOut1Out,
    output logic [WIDTH-1:0] DataOut2Out
);
    logic [WIDTH-1:0] opReg1;
    logic [WIDTH-1:0] opReg2;
    // reset wins over stall; both operands share one load enable so they never split
    always_ff @(posedge clk) begin
        if (rst) begin
            opReg1 <= RST_VAL1;
            opReg2 <= RST_VAL2;
        end else if (!Stall) begin
            opReg1 <= DataOut1In;
            opReg2 <= DataOut2In;
        end
    end
    assign DataOut1Out = opReg1;
    assign DataOut2Out = opReg2;
endmodule

// File: tb/tb_decode_reg.sv
// tb_decode_reg: directed checks of reset, flow, stall hold, reset-under-stall and edge-only updates
module tb_decode_reg;
    logic        clk = 1'b0;
    logic        rst;
    logic        Stall;
    logic [15:0] dataIn1;
    logic [15:0] dataIn2;
    logic [15:0] outA1;
    logic [15:0] outA2;
    logic [15:0] outB1;
    logic [15:0] outB2;
    int          checks = 0;
    int          errors = 0;

    decode_reg dutA (
        .clk(clk), .rst(rst), .Stall(Stall),
        .DataOut1In(dataIn1), .DataOut2In(dataIn2),
        .DataOut1Out(outA1), .DataOut2Out(outA2)
    );

    decode_reg #(.RST_VAL1(16'hDEAD), .RST_VAL2(16'hBEEF)) dutB (
        .clk(clk), .rst(rst), .Stall(Stall),
        .DataOut1In(dataIn1), .DataOut2In(dataIn2),
        .DataOut1Out(outB1), .DataOut2Out(outB2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [15:0] a, input logic [15:0] b);
        rst = r;
        Stall = s;
        dataIn1 = a;
        dataIn2 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chkPair(input string tag, input logic [15:0] e1, input logic [15:0] e2);
        chk({tag, "_op1"}, outA1, e1);
        chk({tag, "_op2"}, outA2, e2);
    endtask

    initial begin
        step(1'b1, 1'b0, 16'h1234, 16'hABCD);
        chkPair("reset", 16'h0000, 16'h0000);
        chk("param_rst1", outB1, 16'hDEAD);
        chk("param_rst2", outB2, 16'hBEEF);
        step(1'b1, 1'b1, 16'h1234, 16'hABCD);
        chkPair("reset_stall", 16'h0000, 16'h0000);
        rst = 1'b0;
        Stall = 1'b0;
        dataIn1 = 16'h0001;
        dataIn2 = 16'h8000;
        #2;
        chkPair("latency_pre_edge", 16'h0000, 16'h0000);
        step(1'b0, 1'b0, 16'h0001, 16'h8000);
        chkPair("flow0", 16'h0001, 16'h8000);
        step(1'b0, 1'b0, 16'hFFFF, 16'h7FFF);
        chkPair("flow1", 16'hFFFF, 16'h7FFF);
        step(1'b0, 1'b0, 16'h5A5A, 16'hA5A5);
        chkPair("flow2", 16'h5A5A, 16'hA5A5);
        chk("paramB_flow", outB1, 16'h5A5A);
        step(1'b0, 1'b0, 16'h1111, 16'h2222);
        chkPair("load_hold", 16'h1111, 16'h2222);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 16'h3333 + 16'(k), 16'h4444 + 16'(k));
            chkPair("stall_hold", 16'h1111, 16'h2222);
        end
        step(1'b0, 1'b0, 16'h5555, 16'h6666);
        chkPair("stall_release", 16'h5555, 16'h6666);
        step(1'b0, 1'b0, 16'h1111, 16'h2222);
        step(1'b0, 1'b1, 16'h7777, 16'h8888);
        chkPair("pre_rst_hold", 16'h1111, 16'h2222);
        step(1'b1, 1'b1, 16'h7777, 16'h8888);
        chkPair("rst_mid_stall", 16'h0000, 16'h0000);
        chk("paramB_rst_mid_stall", outB2, 16'hBEEF);
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b1, 16'h9ABC, 16'hDEF0);
            chkPair("post_rst_stall", 16'h0000, 16'h0000);
        end
        Stall = 1'b0;
        dataIn1 = 16'h9999;
        dataIn2 = 16'h7777;
        #2;
        chkPair("glitch_a", 16'h0000, 16'h0000);
        dataIn1 = 16'h0F0F;
        dataIn2 = 16'hF0F0;
        #2;
        chkPair("glitch_b", 16'h0000, 16'h0000);
        step(1'b0, 1'b0, 16'hCAFE, 16'hF00D);
        chkPair("glitch_edge", 16'hCAFE, 16'hF00D);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
